// File: rtl/mfb_merger_simple_if.sv
// MFB bus bundle for mfb_merger_simple: word content, region framing and handshake.
// The master drives the word and src_rdy; the slave returns dst_rdy.
interface mfb_merger_simple_if #(
    parameter int REGIONS     = 4,
    parameter int REGION_SIZE = 8,
    parameter int BLOCK_SIZE  = 8,
    parameter int ITEM_WIDTH  = 8,
    parameter int META_WIDTH  = 1
);
    localparam int SOF_POS_W = (REGION_SIZE > 2) ? $clog2(REGION_SIZE) : 1;
    localparam int EOF_POS_W = (REGION_SIZE * BLOCK_SIZE > 2) ? $clog2(REGION_SIZE * BLOCK_SIZE) : 1;

    logic [REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] data;
    logic [REGIONS*META_WIDTH-1:0]                         meta;
    logic [REGIONS-1:0]                                    sof;
    logic [REGIONS-1:0]                                    eof;
    logic [REGIONS*SOF_POS_W-1:0]                          sof_pos;
    logic [REGIONS*EOF_POS_W-1:0]                          eof_pos;
    logic                                                  src_rdy;
    logic                                                  dst_rdy;

    modport master (output data, meta, sof, eof, sof_pos, eof_pos, src_rdy, input dst_rdy);
    modport slave  (input data, meta, sof, eof, sof_pos, eof_pos, src_rdy, output dst_rdy);
endinterface

// File: rtl/mfb_merger_simple.sv
// Merges two MFB streams into one, locking onto an input for a whole packet.
// Define MFB_MERGER_SIMPLE_OUT_REG_EN for a one-word output register; otherwise TX is pass-through.
module mfb_merger_simple #(
    parameter int REGIONS     = 4,
    parameter int REGION_SIZE = 8,
    parameter int BLOCK_SIZE  = 8,
    parameter int ITEM_WIDTH  = 8,
    parameter int META_WIDTH  = 1
) (
    input  logic CLK,
    input  logic RESET,
    mfb_merger_simple_if.slave  rx0,
    mfb_merger_simple_if.slave  rx1,
    mfb_merger_simple_if.master tx
);
    localparam int DATA_W    = REGIONS * REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH;
    localparam int META_W    = REGIONS * META_WIDTH;
    localparam int SOF_POS_W = (REGION_SIZE > 2) ? $clog2(REGION_SIZE) : 1;
    localparam int EOF_POS_W = (REGION_SIZE * BLOCK_SIZE > 2) ? $clog2(REGION_SIZE * BLOCK_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t                         state;
    logic                           rr;
    logic                           sel;
    logic                           sel_vld;
    logic                           sel_rdy;
    logic                           rdy_en;
    logic                           xfer;
    logic                           pkt_open;
    logic [DATA_W-1:0]              sel_data;
    logic [META_W-1:0]              sel_meta;
    logic [REGIONS-1:0]             sel_sof;
    logic [REGIONS-1:0]             sel_eof;
    logic [REGIONS*SOF_POS_W-1:0]   sel_sof_pos;
    logic [REGIONS*EOF_POS_W-1:0]   sel_eof_pos;

    always_comb begin
        sel = rr;
        case (state)
            LOCK0:   sel = 1'b0;
            LOCK1:   sel = 1'b1;
            default: begin
                if (rx0.src_rdy && !rx1.src_rdy)
                    sel = 1'b0;
                else if (rx1.src_rdy && !rx0.src_rdy)
                    sel = 1'b1;
            end
        endcase
    end

    assign sel_vld     = sel ? rx1.src_rdy : rx0.src_rdy;
    assign sel_data    = sel ? rx1.data    : rx0.data;
    assign sel_meta    = sel ? rx1.meta    : rx0.meta;
    assign sel_sof     = sel ? rx1.sof     : rx0.sof;
    assign sel_eof     = sel ? rx1.eof     : rx0.eof;
    assign sel_sof_pos = sel ? rx1.sof_pos : rx0.sof_pos;
    assign sel_eof_pos = sel ? rx1.eof_pos : rx0.eof_pos;

    // Walk regions in order; the last frame marker seen decides whether a packet stays open.
    always_comb begin
        pkt_open = (state != IDLE);
        for (int r = 0; r < REGIONS; r++) begin
            if (sel_sof[r] && sel_eof[r])
                pkt_open = (int'(sel_sof_pos[r*SOF_POS_W +: SOF_POS_W]) * BLOCK_SIZE)
                           > int'(sel_eof_pos[r*EOF_POS_W +: EOF_POS_W]);
            else if (sel_sof[r])
                pkt_open = 1'b1;
            else if (sel_eof[r])
                pkt_open = 1'b0;
        end
    end

    assign rdy_en      = sel_rdy && !RESET;
    assign rx0.dst_rdy = rdy_en && !sel;
    assign rx1.dst_rdy = rdy_en && sel;
    assign xfer        = sel_vld && rdy_en;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            rr    <= 1'b0;
        end else if (xfer) begin
            case (state)
                IDLE:    if (pkt_open) state <= sel ? LOCK1 : LOCK0;
                default: if (!pkt_open) state <= IDLE;
            endcase
            if (!pkt_open)
                rr <= !sel;
        end
    end

`ifdef MFB_MERGER_SIMPLE_OUT_REG_EN
    logic                         out_vld;
    logic [DATA_W-1:0]            out_data;
    logic [META_W-1:0]            out_meta;
    logic [REGIONS-1:0]           out_sof;
    logic [REGIONS-1:0]           out_eof;
    logic [REGIONS*SOF_POS_W-1:0] out_sof_pos;
    logic [REGIONS*EOF_POS_W-1:0] out_eof_pos;

    assign sel_rdy = !out_vld || tx.dst_rdy;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            out_vld <= 1'b0;
        else if (sel_rdy)
            out_vld <= sel_vld;
    end

    // Payload needs no reset: it is only observed while out_vld is set.
    always_ff @(posedge CLK) begin
        if (sel_rdy && sel_vld) begin
            out_data    <= sel_data;
            out_meta    <= sel_meta;
            out_sof     <= sel_sof;
            out_eof     <= sel_eof;
            out_sof_pos <= sel_sof_pos;
            out_eof_pos <= sel_eof_pos;
        end
    end

    assign tx.src_rdy = out_vld;
    assign tx.data    = out_data;
    assign tx.meta    = out_meta;
    assign tx.sof     = out_sof;
    assign tx.eof     = out_eof;
    assign tx.sof_pos = out_sof_pos;
    assign tx.eof_pos = out_eof_pos;
`else
    assign sel_rdy    = tx.dst_rdy;
    assign tx.src_rdy = sel_vld && !RESET;
    assign tx.data    = sel_data;
    assign tx.meta    = sel_meta;
    assign tx.sof     = sel_sof;
    assign tx.eof     = sel_eof;
    assign tx.sof_pos = sel_sof_pos;
    assign tx.eof_pos = sel_eof_pos;
`endif
endmodule

// File: tb/tb_mfb_merger_simple.sv
// Directed bench for mfb_merger_simple: arbitration table plus lock, backpressure and reset sequences.
module tb_mfb_merger_simple;
    typedef struct {
        logic [15:0] tag;
        logic [3:0]  sof;
        logic [3:0]  eof;
        logic [11:0] sof_pos;
        logic [23:0] eof_pos;
    } word_t;

    typedef struct {
        bit    v0;
        word_t w0;
        bit    v1;
        word_t w1;
        bit    sel;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    mfb_merger_simple_if rx0_if ();
    mfb_merger_simple_if rx1_if ();
    mfb_merger_simple_if tx_if ();

    mfb_merger_simple dut (.CLK(CLK), .RESET(RESET), .rx0(rx0_if), .rx1(rx1_if), .tx(tx_if));

    int    n_checks = 0;
    int    n_pass = 0;
    word_t exp_q[$];
    word_t q0[$];
    word_t q1[$];
    vec_t  vq[$];
    word_t idle_w;
    bit    in_pkt1 = 0;

    function automatic logic [2047:0] mk_data(input logic [15:0] tag);
        logic [2047:0] d;
        d = '0;
        d[15:0] = tag;
        d[2047:2032] = tag;
        return d;
    endfunction

    function automatic word_t mkw(input logic [15:0] tag, input logic [3:0] sof, input logic [3:0] eof,
                                  input logic [11:0] sp, input logic [23:0] ep);
        word_t w;
        w.tag = tag; w.sof = sof; w.eof = eof; w.sof_pos = sp; w.eof_pos = ep;
        return w;
    endfunction

    function automatic word_t single(input logic [15:0] tag);
        return mkw(tag, 4'b0001, 4'b0001, 12'h0, 24'h7);
    endfunction
    function automatic word_t sof_only(input logic [15:0] tag);
        return mkw(tag, 4'b0001, 4'b0000, 12'h0, 24'h0);
    endfunction
    function automatic word_t mid(input logic [15:0] tag);
        return mkw(tag, 4'b0000, 4'b0000, 12'h0, 24'h0);
    endfunction
    function automatic word_t eof_only(input logic [15:0] tag);
        return mkw(tag, 4'b0000, 4'b0001, 12'h0, 24'h7);
    endfunction
    function automatic logic [15:0] tg(input int i, input int x);
        return 16'h8000 | 16'(i << 4) | 16'(x);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    task automatic drive(input bit which, input bit vld, input word_t w);
        if (!which) begin
            rx0_if.src_rdy = vld; rx0_if.data = mk_data(w.tag); rx0_if.meta = w.tag[3:0];
            rx0_if.sof = w.sof; rx0_if.eof = w.eof; rx0_if.sof_pos = w.sof_pos; rx0_if.eof_pos = w.eof_pos;
        end else begin
            rx1_if.src_rdy = vld; rx1_if.data = mk_data(w.tag); rx1_if.meta = w.tag[3:0];
            rx1_if.sof = w.sof; rx1_if.eof = w.eof; rx1_if.sof_pos = w.sof_pos; rx1_if.eof_pos = w.eof_pos;
        end
    endtask

    task automatic sample_tx();
        word_t w;
        logic  ok;
        if (tx_if.src_rdy === 1'b1 && tx_if.dst_rdy === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL tx_word: got unexpected tag %0h, expected no word", tx_if.data[15:0]);
            end else begin
                w = exp_q.pop_front();
                ok = (tx_if.data === mk_data(w.tag)) && (tx_if.meta === w.tag[3:0]) &&
                     (tx_if.sof === w.sof) && (tx_if.eof === w.eof) &&
                     (tx_if.sof_pos === w.sof_pos) && (tx_if.eof_pos === w.eof_pos);
                if (ok) n_pass++;
                else $display("FAIL tx_word: got tag %0h sof %b eof %b, expected tag %0h sof %b eof %b",
                              tx_if.data[15:0], tx_if.sof, tx_if.eof, w.tag, w.sof, w.eof);
            end
        end
    endtask

    task automatic add_vec(input bit v0, input word_t w0, input bit v1, input word_t w1, input bit sel);
        vec_t v;
        v.v0 = v0; v.w0 = w0; v.v1 = v1; v.w1 = w1; v.sel = sel;
        vq.push_back(v);
    endtask

    // Drain q0/q1 through the DUT; mode 1 toggles tx dst_rdy every cycle.
    task automatic run_queues(input int mode);
        bit a0, a1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0) break;
            if (q0.size() > 0) drive(0, 1, q0[0]); else drive(0, 0, idle_w);
            if (q1.size() > 0) drive(1, 1, q1[0]); else drive(1, 0, idle_w);
            tx_if.dst_rdy = (mode == 0) || (cyc % 2 == 0);
            #1;
            a0 = rx0_if.src_rdy && rx0_if.dst_rdy;
            a1 = rx1_if.src_rdy && rx1_if.dst_rdy;
            if (in_pkt1 && rx0_if.src_rdy) check("lock1_blocks_rx0", rx0_if.dst_rdy, 0);
            sample_tx();
            if (a1) begin
                if (q1[0].sof != 0) in_pkt1 = 1;
                if (q1[0].eof != 0) in_pkt1 = 0;
                void'(q1.pop_front());
            end
            if (a0) void'(q0.pop_front());
            @(negedge CLK);
        end
        check("drain_pending_words", exp_q.size() + q0.size() + q1.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_w = mid(16'h0);
        tx_if.dst_rdy = 1'b1;
        drive(0, 1, single(16'h0AAA));
        drive(1, 1, single(16'h0BBB));

        // Arbitration table; tx_dst_rdy=1 so selected dst_rdy is 1 in either output mode.
        add_vec(1, single(tg(0, 0)),   0, idle_w,           0);
        add_vec(1, single(tg(1, 0)),   1, single(tg(1, 1)), 1);
        add_vec(1, single(tg(2, 0)),   1, single(tg(2, 1)), 0);
        add_vec(1, single(tg(3, 0)),   1, single(tg(3, 1)), 1);
        add_vec(1, sof_only(tg(4, 0)), 1, single(tg(4, 1)), 0);
        add_vec(1, mid(tg(5, 0)),      1, single(tg(5, 1)), 0);
        add_vec(1, eof_only(tg(6, 0)), 1, single(tg(6, 1)), 0);
        add_vec(1, single(tg(7, 0)),   1, single(tg(7, 1)), 1);
        add_vec(1, sof_only(tg(8, 0)), 1, single(tg(8, 1)), 0);
        add_vec(1, mkw(tg(9, 0), 4'b0100, 4'b0001, 12'h0, 24'h7), 1, single(tg(9, 1)), 0);
        add_vec(1, mkw(tg(10, 0), 4'b0000, 4'b0010, 12'h0, 24'h140), 1, single(tg(10, 1)), 0);
        add_vec(1, single(tg(11, 0)),  1, sof_only(tg(11, 1)), 1);
        add_vec(1, single(tg(12, 0)),  1, mid(tg(12, 1)),      1);
        add_vec(1, single(tg(13, 0)),  1, eof_only(tg(13, 1)), 1);
        add_vec(1, mkw(tg(14, 0), 4'b0010, 4'b0010, 12'h008, 24'h240), 1, single(tg(14, 1)), 0);
        add_vec(1, single(tg(15, 0)),  1, sof_only(tg(15, 1)), 1);
        add_vec(1, single(tg(16, 0)),  1, mkw(tg(16, 1), 4'b0100, 4'b0100, 12'h0C0, 24'h005000), 1);
        add_vec(1, single(tg(17, 0)),  1, eof_only(tg(17, 1)), 1);

        @(negedge CLK);
        #1;
        check("reset_tx_src_rdy", tx_if.src_rdy, 0);
        check("reset_rx0_dst_rdy", rx0_if.dst_rdy, 0);
        check("reset_rx1_dst_rdy", rx1_if.dst_rdy, 0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(0, vq[i].v0, vq[i].w0);
            drive(1, vq[i].v1, vq[i].w1);
            tx_if.dst_rdy = 1'b1;
            #1;
            check($sformatf("vec%0d_rx0_dst_rdy", i), rx0_if.dst_rdy, vq[i].sel == 0);
            check($sformatf("vec%0d_rx1_dst_rdy", i), rx1_if.dst_rdy, vq[i].sel == 1);
            exp_q.push_back(vq[i].sel ? vq[i].w1 : vq[i].w0);
            sample_tx();
            @(negedge CLK);
        end

        // RX1 5-word packet under toggling backpressure; RX0 waits behind the lock.
        q0.push_back(single(16'h0A01));
        q0.push_back(single(16'h0A02));
        q1.push_back(sof_only(16'h0B00));
        q1.push_back(mid(16'h0B01));
        q1.push_back(mid(16'h0B02));
        q1.push_back(mid(16'h0B03));
        q1.push_back(eof_only(16'h0B04));
        exp_q.push_back(single(16'h0A01));
        exp_q.push_back(sof_only(16'h0B00));
        exp_q.push_back(mid(16'h0B01));
        exp_q.push_back(mid(16'h0B02));
        exp_q.push_back(mid(16'h0B03));
        exp_q.push_back(eof_only(16'h0B04));
        exp_q.push_back(single(16'h0A02));
        run_queues(1);

        drive(0, 0, idle_w);
        drive(1, 0, idle_w);
        tx_if.dst_rdy = 1'b1;
        #1;
        check("idle_tx_src_rdy", tx_if.src_rdy, 0);
        @(negedge CLK);

        // Reset while locked on RX1 with RR pointing at RX1.
        drive(1, 1, sof_only(16'h0C00));
        #1;
        check("lock1_enter_rdy", rx1_if.dst_rdy, 1);
`ifndef MFB_MERGER_SIMPLE_OUT_REG_EN
        exp_q.push_back(sof_only(16'h0C00));
`endif
        sample_tx();
        @(negedge CLK);
        RESET = 1'b1;
        drive(0, 1, single(16'h0D00));
        drive(1, 1, single(16'h0E00));
        #1;
        check("midpkt_reset_tx_src_rdy", tx_if.src_rdy, 0);
        check("midpkt_reset_rx0_dst_rdy", rx0_if.dst_rdy, 0);
        check("midpkt_reset_rx1_dst_rdy", rx1_if.dst_rdy, 0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("post_reset_rx0_first", rx0_if.dst_rdy, 1);
        check("post_reset_rx1_wait", rx1_if.dst_rdy, 0);
        exp_q.push_back(single(16'h0D00));
        sample_tx();
        @(negedge CLK);
        in_pkt1 = 0;
        q1.push_back(single(16'h0E00));
        exp_q.push_back(single(16'h0E00));
        run_queues(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mfb_merger_simple.md
MFB_MERGER_SIMPLE -- requirements
Module: mfb_merger_simple

Interface
REQ-001 SHALL have parameter REGIONS, default 4, number of MFB regions per word.
REQ-002 SHALL have parameter REGION_SIZE, default 8, blocks per region.
REQ-003 SHALL have parameter BLOCK_SIZE, default 8, items per block.
REQ-004 SHALL have parameter ITEM_WIDTH, default 8, bits per item.
REQ-005 SHALL have parameter META_WIDTH, default 1, metadata bits per region.
REQ-006 SHALL have a single clock, CLK, input, 1 bit.
REQ-007 SHALL have RESET, input, 1 bit, asynchronous, active-high.
REQ-008 SHALL have, for each of the RX0_ and RX1_ prefixes:
- DATA, input, REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH bits.
- META, input, REGIONS*META_WIDTH bits.
- SOF, input, REGIONS bits.
- EOF, input, REGIONS bits.
- SOF_POS, input, REGIONS*max(1,log2(REGION_SIZE)) bits.
- EOF_POS, input, REGIONS*max(1,log2(REGION_SIZE*BLOCK_SIZE)) bits.
- SRC_RDY, input, 1 bit.
- DST_RDY, output, 1 bit.
REQ-009 SHALL have TX_DATA, TX_META, TX_SOF, TX_EOF, TX_SOF_POS, TX_EOF_POS and TX_SRC_RDY as outputs, with the same widths as the RX signals.
REQ-010 SHALL have TX_DST_RDY, input, 1 bit.

Function
REQ-011 SHALL merge two MFB streams into one without interleaving packets; packet and word content SHALL pass unmodified.
REQ-012 SHALL implement an FSM with states IDLE, LOCK0 and LOCK1.
REQ-013 A word transfers on an input when RXx_SRC_RDY=1 and RXx_DST_RDY=1.
REQ-014 In IDLE, SHALL select the single valid input; if both are valid, SHALL select the input indicated by the round-robin pointer RR (0 = RX0).
REQ-015 In LOCKx, SHALL select only RXx; RXy_DST_RDY SHALL be 0.
REQ-016 Per transferred word, SHALL compute pkt_open = 1 when the last asserted SOF region index is greater than the last asserted EOF region index (SOF and EOF in the same region: compare positions, SOF_POS*BLOCK_SIZE > EOF_POS means open).
- In IDLE, a word with no SOF and no EOF leaves pkt_open=0.
- In LOCK, a word with no SOF and no EOF leaves pkt_open=1.
REQ-017 FSM transitions:
- IDLE to LOCKx when a word from x transfers with pkt_open=1.
- LOCKx to IDLE when a word from x transfers with pkt_open=0.
- Otherwise the state holds.
REQ-018 On every transfer that ends with pkt_open=0, RR SHALL be set to the non-served input.
REQ-019 DST_RDY of the unselected input SHALL be 0; DST_RDY of the selected input SHALL follow REQ-020/REQ-021.
REQ-020 Without REQ-027 (pass-through mode):
- TX_* SHALL equal the selected RX signals combinationally.
- Selected DST_RDY SHALL equal TX_DST_RDY.
- Latency is 0 cycles.
- TX_SRC_RDY SHALL be 0 when no input is valid.
REQ-021 With REQ-027 (register mode), see REQ-027.
REQ-022 Input words arriving with SOF in the middle of an already open packet are a protocol violation; behaviour is undefined and need not be checked.

Reset
REQ-023 While RESET=1, SHALL hold state=IDLE, RR=0, TX_SRC_RDY=0, RX0_DST_RDY=0 and RX1_DST_RDY=0.
REQ-024 Reset asserted mid-packet SHALL discard the lock and any registered word; after release, arbitration restarts from IDLE with RR=0.
REQ-025 TX_DATA/META/POS values SHALL be don't-care while TX_SRC_RDY=0.

Configuration
REQ-026 Macro MFB_MERGER_SIMPLE_OUT_REG_EN SHALL control the output register.
REQ-027 With MFB_MERGER_SIMPLE_OUT_REG_EN defined:
- TX_* SHALL come from a one-word output register.
- The register SHALL load when it is empty or TX_DST_RDY=1.
- Selected DST_RDY SHALL equal (!TX_SRC_RDY or TX_DST_RDY).
- Latency is 1 cycle; sustained throughput is 1 word per cycle.
REQ-028 With MFB_MERGER_SIMPLE_OUT_REG_EN undefined, SHALL use pass-through mode (REQ-020).

Verification
REQ-029 RX0 sends single-word packets (SOF[0]=1, EOF[0]=1) every cycle, RX1 idle, TX_DST_RDY=1 -> every word is output in order; throughput is 1 word per cycle.
REQ-030 Both inputs send continuous single-word packets -> output alternates RX0, RX1, RX0, ... starting with RX0 after reset.
REQ-031 RX0 sends a 3-word packet while RX1 is valid throughout -> all 3 RX0 words are output consecutively, then RX1; RX1_DST_RDY=0 during LOCK0.
REQ-032 TX_DST_RDY toggles 1,0,1,0 during a 5-word RX1 packet -> no data is lost or duplicated, word order is preserved, and the state stays LOCK1 until the EOF word.
REQ-033 Word with EOF in region 0 and a new SOF in region 2 from RX0 -> the state stays LOCK0; RX1 is blocked until the next closing word.
REQ-034 RESET pulsed mid-packet in LOCK1 -> TX_SRC_RDY=0 immediately; after release, a valid RX0 is selected first (RR=0); run in both macro settings.
